// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

  localparam logic RUN        = 1'b0;
  localparam logic LOAD_STALL = 1'b1;
  localparam int   REG_ADDR_W = 3;
  localparam int   PERF_CNT_W = 16;

  typedef enum logic {
    ST_RUN        = RUN,
    ST_LOAD_STALL = LOAD_STALL
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
  } hz_ctrl_t;

  function automatic hz_ctrl_t ctrl_default();
    hz_ctrl_t c;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    c.ifid_flush = 1'b0;
    c.idex_write = 1'b1;
    c.idex_flush = 1'b0;
    return c;
  endfunction

  // Freeze holds every stage; no bubble is injected while memory is busy.
  function automatic hz_ctrl_t ctrl_freeze();
    hz_ctrl_t c;
    c.pc_write   = 1'b0;
    c.ifid_write = 1'b0;
    c.ifid_flush = 1'b0;
    c.idex_write = 1'b0;
    c.idex_flush = 1'b0;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrl_redirect();
    hz_ctrl_t c;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    c.ifid_flush = 1'b1;
    c.idex_write = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrl_stall();
    hz_ctrl_t c;
    c.pc_write   = 1'b0;
    c.ifid_write = 1'b0;
    c.ifid_flush = 1'b0;
    c.idex_write = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// Saturating event counter with synchronous clear, used for hazard statistics.
module hazard_sat_cnt
  import pipe_hazard_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  clr,
  input  logic                  inc,
  output logic [PERF_CNT_W-1:0] count
);

  always_ff @(posedge clk_i) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 16-bit 5-stage pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  idex_memread_i,
  input  logic [REG_ADDR_W-1:0] idex_wr_addr_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_busy_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_write_o,
  output logic                  idex_flush_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] stall_cycles_o,
  output logic [PERF_CNT_W-1:0] flush_events_o,
`endif
  output logic                  dbg_state_o,
  output logic [2:0]            dbg_cnt_o
);

  // The first bubble is inserted from RUN, so the stall state covers the rest.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_e state, nxt_state;
  logic [2:0] cnt, nxt_cnt;
  hz_ctrl_t   ctrl;
  logic       hazard;

  // Register 0 is compared like any other address.
  assign hazard = idex_memread_i &&
                  ((id_uses_rs_i && (id_rs_addr_i == idex_wr_addr_i)) ||
                   (id_uses_rt_i && (id_rt_addr_i == idex_wr_addr_i)));

  always_comb begin
    ctrl      = ctrl_default();
    nxt_state = state;
    nxt_cnt   = cnt;
    if (rst_i) begin
      ctrl = ctrl_default();
    end else if (mem_busy_i) begin
      ctrl = ctrl_freeze();
    end else if (ex_redirect_i) begin
      ctrl      = ctrl_redirect();
      nxt_state = ST_RUN;
      nxt_cnt   = '0;
    end else if (state == ST_LOAD_STALL) begin
      ctrl    = ctrl_stall();
      nxt_cnt = cnt - 3'd1;
      if (cnt == 3'd1) begin
        nxt_state = ST_RUN;
      end
    end else if (hazard) begin
      ctrl = ctrl_stall();
      if (LOAD_STALL_CYCLES > 1) begin
        nxt_state = ST_LOAD_STALL;
        nxt_cnt   = STALL_RELOAD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  assign pc_write_o   = ctrl.pc_write;
  assign ifid_write_o = ctrl.ifid_write;
  assign ifid_flush_o = ctrl.ifid_flush;
  assign idex_write_o = ctrl.idex_write;
  assign idex_flush_o = ctrl.idex_flush;
  assign dbg_state_o  = state;
  assign dbg_cnt_o    = cnt;

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_cnt u_stall_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (!ctrl.pc_write),
    .count (stall_cycles_o)
  );

  hazard_sat_cnt u_flush_cnt (
    .clk_i (clk_i),
    .clr   (rst_i),
    .inc   (ctrl.ifid_flush),
    .count (flush_events_o)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with a single-cycle
// load stall and one with a three-cycle load stall share the same inputs.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] id_rs_addr_i = '0;
  logic [2:0] id_rt_addr_i = '0;
  logic       id_uses_rs_i = 1'b0;
  logic       id_uses_rt_i = 1'b0;
  logic       idex_memread_i = 1'b0;
  logic [2:0] idex_wr_addr_i = '0;
  logic       ex_redirect_i = 1'b0;
  logic       mem_busy_i = 1'b0;

  logic pc_a, ifw_a, iff_a, idw_a, idf_a, st_a;
  logic pc_b, ifw_b, iff_b, idw_b, idf_b, st_b;
  logic [2:0] cnt_a, cnt_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
`endif

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush}
  logic [4:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pc_a, ifw_a, iff_a, idw_a, idf_a};
  assign ctrl_b = {pc_b, ifw_b, iff_b, idw_b, idf_b};

  localparam logic [4:0] DEF    = 5'b11010;
  localparam logic [4:0] STALL  = 5'b00011;
  localparam logic [4:0] FREEZE = 5'b00000;
  localparam logic [4:0] REDIR  = 5'b11111;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .idex_memread_i(idex_memread_i), .idex_wr_addr_i(idex_wr_addr_i),
    .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
    .pc_write_o(pc_a), .ifid_write_o(ifw_a), .ifid_flush_o(iff_a),
    .idex_write_o(idw_a), .idex_flush_o(idf_a),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles_o(stall_a), .flush_events_o(flush_a),
`endif
    .dbg_state_o(st_a), .dbg_cnt_o(cnt_a)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .idex_memread_i(idex_memread_i), .idex_wr_addr_i(idex_wr_addr_i),
    .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
    .pc_write_o(pc_b), .ifid_write_o(ifw_b), .ifid_flush_o(iff_b),
    .idex_write_o(idw_b), .idex_flush_o(idf_b),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles_o(stall_b), .flush_events_o(flush_b),
`endif
    .dbg_state_o(st_b), .dbg_cnt_o(cnt_b)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 after.
  task automatic step(input logic rst, input logic memread, input logic [2:0] wr,
                      input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                      input logic urt, input logic redir, input logic busy);
    @(posedge clk_i);
    #1;
    rst_i = rst; idex_memread_i = memread; idex_wr_addr_i = wr;
    id_rs_addr_i = rs; id_rt_addr_i = rt; id_uses_rs_i = urs; id_uses_rt_i = urt;
    ex_redirect_i = redir; mem_busy_i = busy;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rs_hazard(input logic redir);
    step(1'b0, 1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, redir, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with hazard inputs present: outputs stay at defaults.
    step(1'b1, 1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_a", ctrl_a, DEF);
    chk("rst_b", ctrl_b, DEF);
    step(1'b1, 1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_state_b", st_b, 1'b0);

    // Load-use on RS.
    rs_hazard(1'b0);
    chk("lu1_a", ctrl_a, STALL);
    chk("lu1_b", ctrl_b, STALL);
    // Second stall cycle of b gets a memory freeze.
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("busy_a", ctrl_a, FREEZE);
    chk("busy_b", ctrl_b, FREEZE);
    chk("busy_state_b", st_b, 1'b1);
    chk("busy_cnt_b", cnt_b, 3'd2);
    idle();
    chk("post1_a", ctrl_a, DEF);
    chk("lu2_b", ctrl_b, STALL);
    chk("lu2_cnt_b", cnt_b, 3'd2);
    idle();
    chk("lu3_b", ctrl_b, STALL);
    chk("lu3_cnt_b", cnt_b, 3'd1);
    idle();
    chk("lu_done_b", ctrl_b, DEF);
    chk("lu_done_state_b", st_b, 1'b0);

    // Redirect wins over a matching hazard; nothing stalls afterwards.
    rs_hazard(1'b1);
    chk("redir_a", ctrl_a, REDIR);
    chk("redir_b", ctrl_b, REDIR);
    idle();
    chk("redir_after_a", ctrl_a, DEF);
    chk("redir_after_b", ctrl_b, DEF);

    // RT matches but is unused; then RS matches without memread.
    step(1'b0, 1'b1, 3'd5, 3'd2, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rt_unused_a", ctrl_a, DEF);
    chk("rt_unused_b", ctrl_b, DEF);
    step(1'b0, 1'b0, 3'd5, 3'd5, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("no_memread_a", ctrl_a, DEF);
    chk("no_memread_b", ctrl_b, DEF);

    // Register 0 through RT; hazard kept on during b's stall is ignored.
    step(1'b0, 1'b1, 3'd0, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("r0_a", ctrl_a, STALL);
    chk("r0_b", ctrl_b, STALL);
    step(1'b0, 1'b1, 3'd0, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("r0_hold_a", ctrl_a, STALL);
    chk("r0_hold_b", ctrl_b, STALL);
    chk("r0_hold_cnt_b", cnt_b, 3'd2);
    idle();
    chk("r0_end_a", ctrl_a, DEF);
    chk("r0_end_b", ctrl_b, STALL);
    idle();
    chk("r0_run_b", ctrl_b, DEF);

    // Redirect during a load stall returns to RUN with cnt cleared.
    rs_hazard(1'b0);
    chk("ls_enter_b", ctrl_b, STALL);
    rs_hazard(1'b1);
    chk("ls_redir_b", ctrl_b, REDIR);
    idle();
    chk("ls_redir_after_b", ctrl_b, DEF);
    chk("ls_redir_state_b", st_b, 1'b0);
    chk("ls_redir_cnt_b", cnt_b, 3'd0);

    // Freeze outranks redirect.
    step(1'b0, 1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("busy_redir_a", ctrl_a, FREEZE);
    chk("busy_redir_b", ctrl_b, FREEZE);

    // Reset in the middle of a stall (cnt=2).
    rs_hazard(1'b0);
    chk("rst_mid_enter_b", ctrl_b, STALL);
    step(1'b1, 1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_a", ctrl_a, DEF);
    chk("rst_mid_b", ctrl_b, DEF);
    idle();
    chk("rst_mid_after_b", ctrl_b, DEF);
    chk("rst_mid_state_b", st_b, 1'b0);
    chk("rst_mid_cnt_b", cnt_b, 3'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt_b", stall_b, 16'd0);
    chk("rst_flush_cnt_b", flush_b, 16'd0);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("flush_events_a", flush_a, 16'd2);
    chk("flush_events_b", flush_b, 16'd2);
    // Instance a stalls on every hazard cycle: 65534 cycles, then 3 more.
    for (int i = 0; i < 65534; i++) begin
      rs_hazard(1'b0);
    end
    idle();
    chk("stall_fffe_a", stall_a, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      rs_hazard(1'b0);
    end
    idle();
    chk("stall_sat_a", stall_a, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Hazard controller for the 16-bit 5-stage pipeline; drives the backward-flowing control for stalls and flushes.
- Consumes the ID/EX pipeline register's MEM/WB control and destination fields, ID-stage source addresses, and EX-stage branch/jump resolution.
- Drives PC write-enable, IF/ID write/flush and ID/EX write/flush (bubble insertion).
- Holds a small FSM for multi-cycle load-use stalls, plus optional performance counters.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- id_rs_addr_i  in  3  RS address of the instruction in ID (instr[12:10]).
- id_rt_addr_i  in  3  RT address of the instruction in ID (instr[9:7]).
- id_uses_rs_i  in  1  instruction in ID reads RS.
- id_uses_rt_i  in  1  instruction in ID reads RT.
- idex_memread_i  in  1  ID/EX MEM control bit 0 (memRead).
- idex_wr_addr_i  in  3  ID/EX destination register (post RegDst select).
- ex_redirect_i  in  1  EX resolved a taken branch or jump this cycle.
- mem_busy_i  in  1  data memory not ready; whole pipe must freeze.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  IF/ID register load zeros.
- idex_write_o  out  1  ID/EX register load enable.
- idex_flush_o  out  1  ID/EX loads all-zero control (bubble).
- stall_cycles_o  out  16  cycles with pc_write_o=0 (only with HAZARD_PERF_CNT_EN).
- flush_events_o  out  16  redirect flushes taken (only with HAZARD_PERF_CNT_EN).

## Operation
- hazard = idex_memread_i && ((id_uses_rs_i && id_rs_addr_i==idex_wr_addr_i) || (id_uses_rt_i && id_rt_addr_i==idex_wr_addr_i)).
- Register 0 is not exempt from the hazard compare.
- FSM states: RUN, LOAD_STALL. A 3-bit counter cnt is valid in LOAD_STALL.
- Default outputs: pc_write=1, ifid_write=1, idex_write=1, both flushes=0.
- Priority, evaluated each cycle in both states: mem_busy_i > ex_redirect_i > load-use.

RUN state:
- mem_busy_i: pc_write=ifid_write=idex_write=0, no flush; state held.
- ex_redirect_i: ifid_flush=1, idex_flush=1, pc_write=1; stay RUN.
- hazard: pc_write=ifid_write=0, idex_flush=1.
  - If LOAD_STALL_CYCLES>1: go to LOAD_STALL, cnt<=LOAD_STALL_CYCLES-1.
  - Otherwise stay RUN.

LOAD_STALL state:
- Each cycle: pc_write=ifid_write=0, idex_flush=1, cnt decrements.
- When cnt==1: next state is RUN.
- mem_busy_i: full freeze and cnt holds. Freeze overrides idex_flush, so idex_flush=0 during a freeze.
- ex_redirect_i: redirect outputs as in RUN; return to RUN; cnt cleared.
- New hazard in LOAD_STALL: ignored; re-evaluated in RUN.

Flush vs write:
- A flush output implies the matching write enable is 1.
- ifid_flush and ifid_write=0 never assert together.

## Timing
- Outputs are Mealy, combinational from current state and inputs; they take effect at the same rising edge.
- Load-use adds exactly LOAD_STALL_CYCLES bubbles when mem_busy_i is low.
- Redirect costs 2 squashed instructions (IF/ID and ID/EX).
- Reset cycle (rst_i=1):
  - Outputs forced to defaults: pc_write=1, ifid_write=1, idex_write=1, flushes=0.
  - State<=RUN, cnt<=0, counters<=0.
- Reset during LOAD_STALL abandons the stall; the next cycle is RUN.
- Inputs are sampled only when rst_i=0.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles_o increments on each non-reset cycle with pc_write_o=0.
  - flush_events_o increments on each cycle with ifid_flush_o=1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both ports and their counter logic are absent. Control behaviour is identical.

## Structure
- Shared package pipe_hazard_pkg:
  - State encoding localparams: RUN=1'b0, LOAD_STALL=1'b1.
  - REG_ADDR_W=3.
  - PERF_CNT_W=16.
- Sub-module hazard_sat_cnt: PERF_CNT_W-bit saturating counter with synchronous clear and increment enable; instantiated twice under the macro.

## Test plan
- idex_memread=1, idex_wr_addr=3, id_rs=3, id_uses_rs=1, LOAD_STALL_CYCLES=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1, then defaults.
- Same hazard with LOAD_STALL_CYCLES=3 -> exactly 3 consecutive stall cycles. Assert mem_busy_i on the 2nd -> freeze (all writes 0, no flush) and cnt held; total stall cycles = 3 + busy cycles.
- ex_redirect_i=1 together with a matching hazard -> ifid_flush=1, idex_flush=1, pc_write=1; no stall follows.
- id_uses_rt=0, id_rt=idex_wr_addr=5, idex_memread=1 -> no stall. Repeat with idex_memread=0 and a matching RS -> no stall.
- rst_i=1 mid LOAD_STALL (cnt=2) -> defaults in the reset cycle; RUN afterwards with no residual stall; perf counters read 0.
- HAZARD_PERF_CNT_EN: preload stall count 16'hFFFE and apply 3 stall cycles -> stall_cycles_o=16'hFFFF. Two redirects -> flush_events_o=2.
